// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps a 2^N-entry truth table through a gate under
// test, samples its response after a programmable settle time and compares
// it against a latched expected table. The observed table, the mismatch
// count, the first mismatching index and a pass flag are held until the next
// accepted start.
module gate_truth_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [2**N-1:0]   expected,
  output logic [N-1:0]      gate_in,
  input  logic              gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2**N-1:0]   observed,
  output logic [N:0]        err_count,
  output logic [N-1:0]      first_err_idx
);

  localparam int          T        = 2 ** N;
  localparam logic [7:0]  CNT_LOAD = 8'(SETTLE - 1);
  localparam logic [N-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gin_q, gin_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [T-1:0]   exp_q, exp_d;
  logic [T-1:0]   obs_q, obs_d;
  logic [N:0]     err_q, err_d;
  logic [N-1:0]   fidx_q, fidx_d;
  logic           pass_q, pass_d;
  logic           mism;

  // Register all sweep state; every output returns to zero on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gin_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      obs_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gin_q   <= gin_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: accept start in IDLE, step vectors in RUN, and fold the
  // last sample into pass on the way into DONE.
  always_comb begin
    state_d = state_q;
    gin_d   = gin_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    pass_d  = pass_q;
    mism    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          obs_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          pass_d  = 1'b0;
          gin_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          obs_d[gin_q] = gate_out;
          mism = (gate_out != exp_q[gin_q]);
          if (mism) begin
            err_d = err_q + 1'b1;
            // err_q still zero means this is the first mismatch of the sweep
            if (err_q == '0) begin
              fidx_d = gin_q;
            end
          end
          if (gin_q != LAST_VEC) begin
            gin_d = gin_q + 1'b1;
            cnt_d = CNT_LOAD;
          end else begin
            gin_d   = '0;
            pass_d  = (err_d == '0);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gate_in       = gin_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign observed      = obs_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;

endmodule
